// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and arithmetic helpers for the digit-serial adder
package serial_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter width for WIDTH/DIGIT digits; a single-digit operation still needs one bit.
  function automatic int cnt_width(input int width, input int digit);
    return (width / digit > 1) ? $clog2(width / digit) : 1;
  endfunction

  // Full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder that also exposes the carry into its top bit
module digit_adder
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c = '0;
    s = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
  end

  assign cout  = c[DIGIT];
  assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first digit-serial adder/subtractor with IDLE/RUN/DONE sequencing
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $fatal(1, "serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DIGIT-1:0] a_dig, b_dig, d_sum;
  logic             d_cout, d_ctop, last;

  assign a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign last  = cnt_q == CW'(N - 1);

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry_q),
    .s    (d_sum),
    .cout (d_cout),
    .c_top(d_ctop)
  );

  // Next-state: capture on accept (b pre-inverted for subtract), one digit per RUN cycle, flags on the last digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = cin;
    end else if (state_q == RUN) begin
      sum_d[int'(cnt_q) * DIGIT +: DIGIT] = d_sum;
      carry_d = d_cout;
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? DONE : RUN;
      cout_d  = last ? d_cout : cout_q;
      ovf_d   = last ? d_cout ^ d_ctop : ovf_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  // State and registered outputs; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
